// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the framed SPI register-write slave.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        WR   = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam int HDR_W      = 8;
    localparam int HDR_RD_BIT = 7;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one SPI pin, with rise/fall detection behind the last stage.
module spi_edge_sync #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // One extra history flop so edge detection only ever sees fully synchronised values.
    logic [STAGES:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= {(STAGES + 1){INIT}};
        end else begin
            sync_reg <= {sync_reg[STAGES-1:0], din};
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = sync_reg[STAGES-1] & ~sync_reg[STAGES];
    assign fall  = ~sync_reg[STAGES-1] & sync_reg[STAGES];

endmodule

// File: rtl/spi_reg_slave.sv
// Framed SPI slave: header byte then data words, issuing auto-incrementing register writes.
// Define SPI_READBACK_EN to add rd_addr/rd_data/miso register readback for read frames.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              write_en,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        word_cnt
`ifdef SPI_READBACK_EN
    ,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              miso
`endif
);

    localparam logic [4:0] HDR_LAST  = 5'(HDR_W - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);

    logic ss_lvl_unused, ss_rise, ss_fall;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .din(ss),
        .level(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(CPOL != 0)) u_sclk_sync (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t              state_reg;
    logic [4:0]          bit_cnt_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [ADDR_W-1:0]   ptr_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                write_en_reg;
    logic                frame_done_reg;
    logic                frame_err_reg;
    logic [7:0]          word_cnt_reg;

    logic                sample_edge;
    logic                sample_now;
    logic [DATA_W-1:0]   shift_in;
    logic [4:0]          word_last;
    logic                word_done;
    logic [4:0]          bit_cnt_next;

    always_comb begin
        sample_edge  = (CPOL == CPHA) ? sclk_rise : sclk_fall;
        sample_now   = sample_edge && (state_reg != IDLE);
        shift_in     = {shift_reg[DATA_W-2:0], mosi_lvl};
        word_last    = (state_reg == HDR) ? HDR_LAST : DATA_LAST;
        word_done    = sample_now && (bit_cnt_reg == word_last);
        bit_cnt_next = bit_cnt_reg;
        if (word_done) begin
            bit_cnt_next = 5'd0;
        end else if (sample_now) begin
            bit_cnt_next = bit_cnt_reg + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 5'd0;
            shift_reg      <= '0;
            ptr_reg        <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            write_en_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            word_cnt_reg   <= 8'd0;
        end else begin
            write_en_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (ss_fall) begin
                // Also taken mid-frame: a select glitch silently restarts the header.
                state_reg    <= HDR;
                bit_cnt_reg  <= 5'd0;
                shift_reg    <= '0;
                word_cnt_reg <= 8'd0;
            end else if (state_reg != IDLE) begin
                bit_cnt_reg <= bit_cnt_next;
                if (sample_now) begin
                    shift_reg <= shift_in;
                end
                if (word_done) begin
                    case (state_reg)
                        HDR: begin
                            ptr_reg   <= shift_in[ADDR_W-1:0];
                            state_reg <= shift_in[HDR_RD_BIT] ? RD : WR;
                        end
                        WR: begin
                            addr_reg     <= ptr_reg;
                            data_reg     <= shift_in;
                            write_en_reg <= 1'b1;
                            ptr_reg      <= ptr_reg + ADDR_W'(1);
                            word_cnt_reg <= sat_inc8(word_cnt_reg);
                        end
                        RD: begin
                            ptr_reg      <= ptr_reg + ADDR_W'(1);
                            word_cnt_reg <= sat_inc8(word_cnt_reg);
                        end
                        default: ;
                    endcase
                end
                // A sample landing in the same clk as deselect is already folded into bit_cnt_next.
                if (ss_rise) begin
                    state_reg   <= IDLE;
                    bit_cnt_reg <= 5'd0;
                    if (bit_cnt_next == 5'd0) begin
                        frame_done_reg <= 1'b1;
                    end else begin
                        frame_err_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign addr       = addr_reg;
    assign data       = data_reg;
    assign write_en   = write_en_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign word_cnt   = word_cnt_reg;

`ifdef SPI_READBACK_EN
    logic                shift_edge;
    logic [DATA_W-1:0]   tx_reg;
    logic                miso_reg;
    logic                load_pend_reg;

    assign shift_edge = (CPOL == CPHA) ? sclk_fall : sclk_rise;

    // The load is deferred to the next shift edge so rd_data reflects the freshly updated pointer;
    // that edge is also the one on which the word's MSB must appear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            load_pend_reg <= 1'b0;
        end else if (ss_fall) begin
            tx_reg        <= '0;
            miso_reg      <= 1'b0;
            load_pend_reg <= 1'b0;
        end else begin
            if (word_done && (state_reg == RD ||
                              (state_reg == HDR && shift_in[HDR_RD_BIT]))) begin
                load_pend_reg <= 1'b1;
            end
            if (shift_edge && state_reg == RD) begin
                if (load_pend_reg) begin
                    miso_reg      <= rd_data[DATA_W-1];
                    tx_reg        <= {rd_data[DATA_W-2:0], 1'b0};
                    load_pend_reg <= 1'b0;
                end else begin
                    miso_reg <= tx_reg[DATA_W-1];
                    tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign rd_addr = ptr_reg;
    assign miso    = ss ? 1'b0 : miso_reg;
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench: directed frames in all SPI modes plus randomized frames against a write-list model.
module tb_spi_reg_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ss_a   [4];
    logic        sclk_a [4];
    logic        mosi_a [4];
    logic [4:0]  addr_a [4];
    logic [15:0] data_a [4];
    logic [7:0]  data0;
    logic        we_a   [4];
    logic        fd_a   [4];
    logic        fe_a   [4];
    logic [7:0]  wc_a   [4];

    assign data_a[0] = {8'h00, data0};

`ifdef SPI_READBACK_EN
    logic [4:0]  rd_addr_a [4];
    logic        miso_a    [4];
    logic [7:0]  rd_data0;
    logic [15:0] rd_data_a [1:3];
    assign rd_data0 = 8'h40 + {3'b000, rd_addr_a[0]};
`endif

    spi_reg_slave #(.ADDR_W(5), .DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .ss(ss_a[0]), .sclk(sclk_a[0]), .mosi(mosi_a[0]),
        .addr(addr_a[0]), .data(data0), .write_en(we_a[0]),
        .frame_done(fd_a[0]), .frame_err(fe_a[0]), .word_cnt(wc_a[0])
`ifdef SPI_READBACK_EN
        , .rd_addr(rd_addr_a[0]), .rd_data(rd_data0), .miso(miso_a[0])
`endif
    );

    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_mode
`ifdef SPI_READBACK_EN
            assign rd_data_a[gi] = 16'h0040 + {11'd0, rd_addr_a[gi]};
`endif
            spi_reg_slave #(.ADDR_W(5), .DATA_W(16), .CPOL(gi / 2), .CPHA(gi % 2),
                            .SYNC_STAGES(3)) dut (
                .clk(clk), .rst(rst), .ss(ss_a[gi]), .sclk(sclk_a[gi]), .mosi(mosi_a[gi]),
                .addr(addr_a[gi]), .data(data_a[gi]), .write_en(we_a[gi]),
                .frame_done(fd_a[gi]), .frame_err(fe_a[gi]), .word_cnt(wc_a[gi])
`ifdef SPI_READBACK_EN
                , .rd_addr(rd_addr_a[gi]), .rd_data(rd_data_a[gi]), .miso(miso_a[gi])
`endif
            );
        end
    endgenerate

    typedef struct packed {
        logic [7:0]  inst;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t wr_q [$];
    int  fd_cnt [4];
    int  fe_cnt [4];
    int  checks = 0;
    int  errors = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (we_a[k]) wr_q.push_back('{inst: 8'(k), addr: 8'(addr_a[k]), data: data_a[k]});
            if (fd_a[k]) fd_cnt[k]++;
            if (fe_a[k]) fe_cnt[k]++;
        end
    end

    function automatic logic miso_of(input int i);
`ifdef SPI_READBACK_EN
        return miso_a[i];
`else
        return (i < 0);
`endif
    endfunction

    task automatic clear_obs();
        wr_q.delete();
        for (int k = 0; k < 4; k++) begin
            fd_cnt[k] = 0;
            fe_cnt[k] = 0;
        end
    endtask

    // Master: half sclk period of 80 time units (8 clk cycles).
    task automatic spi_bits(input int i, input logic [15:0] val, input int n, output logic [15:0] rx);
        logic cpol;
        logic cpha;
        cpol = (i >= 2);
        cpha = ((i % 2) == 1);
        rx = 16'h0;
        for (int b = n - 1; b >= 0; b--) begin
            if (!cpha) begin
                mosi_a[i] = val[b];
                #80;
                sclk_a[i] = ~cpol;
                rx = {rx[14:0], miso_of(i)};
                #80;
                sclk_a[i] = cpol;
            end else begin
                sclk_a[i] = ~cpol;
                mosi_a[i] = val[b];
                #80;
                sclk_a[i] = cpol;
                rx = {rx[14:0], miso_of(i)};
                #80;
            end
        end
    endtask

    task automatic send_frame(input int i, input logic [7:0] hdr, input logic [15:0] w [8],
                              input int nw, input int part_bits, input logic [15:0] part_val);
        logic [15:0] rx;
        int dw;
        dw = (i == 0) ? 8 : 16;
        ss_a[i] = 1'b0;
        #80;
        spi_bits(i, {8'h00, hdr}, 8, rx);
        for (int k = 0; k < nw; k++) spi_bits(i, w[k], dw, rx);
        if (part_bits > 0) spi_bits(i, part_val, part_bits, rx);
        #80;
        ss_a[i] = 1'b1;
        #200;
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        #2;
        checks++; if (addr_a[0] !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", addr_a[0]); end
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", data0); end
        checks++; if (we_a[0] !== 1'b0) begin errors++; $display("FAIL reset_write_en: got %b expected 0", we_a[0]); end
        checks++; if (fd_a[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", fd_a[0]); end
        checks++; if (fe_a[0] !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", fe_a[0]); end
        checks++; if (wc_a[0] !== 8'd0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", wc_a[0]); end
`ifdef SPI_READBACK_EN
        checks++; if (miso_a[0] !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso_a[0]); end
`endif
        rst = 1'b1;
        #200;
    endtask

    task automatic test_mode0_basic();
        logic [15:0] w [8];
        wr_t exp_q [$];
        w = '{default: 16'h0};
        w[0] = 16'h00A5; w[1] = 16'h005A;
        exp_q = '{'{inst: 8'd0, addr: 8'd3, data: 16'h00A5}, '{inst: 8'd0, addr: 8'd4, data: 16'h005A}};
        clear_obs();
        send_frame(0, 8'h03, w, 2, 0, 16'h0);
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            checks++; if (wr_q[k] !== exp_q[k]) begin errors++; $display("FAIL basic_write%0d: got %h expected %h", k, wr_q[k], exp_q[k]); end
        end
        checks++; if (wc_a[0] !== 8'd2) begin errors++; $display("FAIL basic_word_cnt: got %0d expected 2", wc_a[0]); end
        checks++; if (fd_cnt[0] != 1) begin errors++; $display("FAIL basic_frame_done: got %0d expected 1", fd_cnt[0]); end
        checks++; if (fe_cnt[0] != 0) begin errors++; $display("FAIL basic_frame_err: got %0d expected 0", fe_cnt[0]); end
    endtask

    task automatic test_wrap();
        logic [15:0] w [8];
        wr_t exp_q [$];
        w = '{default: 16'h0};
        w[0] = 16'h0011; w[1] = 16'h0022; w[2] = 16'h0033;
        exp_q = '{'{inst: 8'd0, addr: 8'd31, data: 16'h0011}, '{inst: 8'd0, addr: 8'd0, data: 16'h0022},
                  '{inst: 8'd0, addr: 8'd1, data: 16'h0033}};
        clear_obs();
        send_frame(0, 8'h1F, w, 3, 0, 16'h0);
        checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
            checks++; if (wr_q[k] !== exp_q[k]) begin errors++; $display("FAIL wrap_write%0d: got %h expected %h", k, wr_q[k], exp_q[k]); end
        end
        checks++; if (wc_a[0] !== 8'd3) begin errors++; $display("FAIL wrap_word_cnt: got %0d expected 3", wc_a[0]); end
    endtask

    task automatic test_abort();
        logic [15:0] w [8];
        wr_t exp_q [$];
        w = '{default: 16'h0};
        w[0] = 16'h00FF;
        exp_q = '{'{inst: 8'd0, addr: 8'd2, data: 16'h00FF}};
        clear_obs();
        send_frame(0, 8'h02, w, 1, 4, 16'h000A);
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL abort_count: got %0d expected 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            checks++; if (wr_q[0] !== exp_q[0]) begin errors++; $display("FAIL abort_write: got %h expected %h", wr_q[0], exp_q[0]); end
        end
        checks++; if (fe_cnt[0] != 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", fe_cnt[0]); end
        checks++; if (fd_cnt[0] != 0) begin errors++; $display("FAIL abort_frame_done: got %0d expected 0", fd_cnt[0]); end
        checks++; if (wc_a[0] !== 8'd1) begin errors++; $display("FAIL abort_word_cnt: got %0d expected 1", wc_a[0]); end
    endtask

    task automatic test_modes();
        logic [15:0] w [8];
        wr_t exp_e;
        w = '{default: 16'h0};
        w[0] = 16'hBEEF;
        for (int i = 1; i < 4; i++) begin
            exp_e = '{inst: 8'(i), addr: 8'd0, data: 16'hBEEF};
            clear_obs();
            send_frame(i, 8'h00, w, 1, 0, 16'h0);
            checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL mode%0d_count: got %0d expected 1", i, wr_q.size()); end
            if (wr_q.size() > 0) begin
                checks++; if (wr_q[0] !== exp_e) begin errors++; $display("FAIL mode%0d_write: got %h expected %h", i, wr_q[0], exp_e); end
            end
            checks++; if (fd_cnt[i] != 1) begin errors++; $display("FAIL mode%0d_frame_done: got %0d expected 1", i, fd_cnt[i]); end
            checks++; if (wc_a[i] !== 8'd1) begin errors++; $display("FAIL mode%0d_word_cnt: got %0d expected 1", i, wc_a[i]); end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] rx;
        logic [15:0] w [8];
        wr_t exp_e;
        w = '{default: 16'h0};
        w[0] = 16'h0001;
        exp_e = '{inst: 8'd0, addr: 8'd5, data: 16'h0001};
        clear_obs();
        ss_a[0] = 1'b0;
        #80;
        spi_bits(0, 16'h0003, 8, rx);
        spi_bits(0, 16'h000F, 4, rx);
        #33;
        rst = 1'b0;
        #1;
        checks++; if (addr_a[0] !== 5'd0) begin errors++; $display("FAIL arst_addr: got %0h expected 0", addr_a[0]); end
        checks++; if (data0 !== 8'd0) begin errors++; $display("FAIL arst_data: got %0h expected 0", data0); end
        checks++; if (we_a[0] !== 1'b0) begin errors++; $display("FAIL arst_write_en: got %b expected 0", we_a[0]); end
        checks++; if (fd_a[0] !== 1'b0) begin errors++; $display("FAIL arst_frame_done: got %b expected 0", fd_a[0]); end
        checks++; if (fe_a[0] !== 1'b0) begin errors++; $display("FAIL arst_frame_err: got %b expected 0", fe_a[0]); end
        checks++; if (wc_a[0] !== 8'd0) begin errors++; $display("FAIL arst_word_cnt: got %0d expected 0", wc_a[0]); end
        #50;
        ss_a[0] = 1'b1;
        #100;
        rst = 1'b1;
        #200;
        send_frame(0, 8'h05, w, 1, 0, 16'h0);
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL arst_next_count: got %0d expected 1", wr_q.size()); end
        if (wr_q.size() > 0) begin
            checks++; if (wr_q[0] !== exp_e) begin errors++; $display("FAIL arst_next_write: got %h expected %h", wr_q[0], exp_e); end
        end
        checks++; if (fd_cnt[0] != 1) begin errors++; $display("FAIL arst_next_frame_done: got %0d expected 1", fd_cnt[0]); end
        checks++; if (fe_cnt[0] != 0) begin errors++; $display("FAIL arst_next_frame_err: got %0d expected 0", fe_cnt[0]); end
    endtask

    // Model: a write frame produces one write per completed word at (header addr + k) mod 32.
    task automatic test_random();
        logic [15:0] w [8];
        logic [7:0]  hdr;
        logic [15:0] mask;
        logic [15:0] pval;
        wr_t exp_q [$];
        int i, nw, part, dw;
        for (int f = 0; f < 24; f++) begin
            i    = $urandom_range(0, 3);
            dw   = (i == 0) ? 8 : 16;
            mask = (i == 0) ? 16'h00FF : 16'hFFFF;
            hdr  = 8'($urandom_range(0, 255));
            nw   = $urandom_range(0, 4);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dw - 1) : 0;
            pval = 16'($urandom);
            w = '{default: 16'h0};
            for (int k = 0; k < nw; k++) w[k] = 16'($urandom) & mask;
            exp_q.delete();
            if (hdr[7] == 1'b0) begin
                for (int k = 0; k < nw; k++)
                    exp_q.push_back('{inst: 8'(i), addr: 8'((int'(hdr) % 32 + k) % 32), data: w[k]});
            end
            clear_obs();
            send_frame(i, hdr, w, nw, part, pval);
            checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d (hdr %h inst %0d)", f, wr_q.size(), exp_q.size(), hdr, i); end
            for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
                checks++; if (wr_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand%0d_write%0d: got %h expected %h", f, k, wr_q[k], exp_q[k]); end
            end
            checks++; if (wc_a[i] !== 8'(nw)) begin errors++; $display("FAIL rand%0d_word_cnt: got %0d expected %0d", f, wc_a[i], nw); end
            checks++; if (fd_cnt[i] != ((part == 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_frame_done: got %0d expected %0d", f, fd_cnt[i], (part == 0) ? 1 : 0); end
            checks++; if (fe_cnt[i] != ((part != 0) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_frame_err: got %0d expected %0d", f, fe_cnt[i], (part != 0) ? 1 : 0); end
        end
    endtask

`ifdef SPI_READBACK_EN
    task automatic test_readback();
        logic [15:0] rx;
        clear_obs();
        ss_a[0] = 1'b0;
        #80;
        spi_bits(0, 16'h0084, 8, rx);
        checks++; if (rd_addr_a[0] !== 5'd4) begin errors++; $display("FAIL rb_rd_addr0: got %0d expected 4", rd_addr_a[0]); end
        spi_bits(0, 16'h0000, 8, rx);
        checks++; if (rx[7:0] !== 8'h44) begin errors++; $display("FAIL rb_byte0: got %h expected 44", rx[7:0]); end
        checks++; if (rd_addr_a[0] !== 5'd5) begin errors++; $display("FAIL rb_rd_addr1: got %0d expected 5", rd_addr_a[0]); end
        spi_bits(0, 16'h0000, 8, rx);
        checks++; if (rx[7:0] !== 8'h45) begin errors++; $display("FAIL rb_byte1: got %h expected 45", rx[7:0]); end
        #80;
        ss_a[0] = 1'b1;
        #200;
        checks++; if (miso_a[0] !== 1'b0) begin errors++; $display("FAIL rb_miso_idle: got %b expected 0", miso_a[0]); end
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL rb_no_write: got %0d expected 0", wr_q.size()); end
        checks++; if (wc_a[0] !== 8'd2) begin errors++; $display("FAIL rb_word_cnt: got %0d expected 2", wc_a[0]); end
        checks++; if (fd_cnt[0] != 1) begin errors++; $display("FAIL rb_frame_done: got %0d expected 1", fd_cnt[0]); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 4; k++) begin
            ss_a[k]   = 1'b1;
            sclk_a[k] = (k >= 2);
            mosi_a[k] = 1'b0;
        end
        test_reset();
        test_mode0_basic();
        test_wrap();
        test_abort();
        test_modes();
        test_async_reset();
        test_random();
`ifdef SPI_READBACK_EN
        test_readback();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
